// File: rtl/bus_arbiter.sv
// Round-robin arbiter multiplexing N_MASTERS bus masters onto one slave port.
// Grants combinationally in the request cycle; holds ownership across slave stalls and locked bursts.
module bus_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_address,
    input  logic [N_MASTERS-1:0]              m_read,
    input  logic [N_MASTERS-1:0]              m_write,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_data_wr,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_mask,
    input  logic [N_MASTERS-1:0]              m_lock,
    output logic [N_MASTERS-1:0]              m_stall,
    output logic [N_MASTERS*DATA_WIDTH-1:0]   m_data_rd,
    output logic [N_MASTERS*DATA_WIDTH-1:0]   m_data_rd_2,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic                              s_read,
    output logic                              s_write,
    output logic [DATA_WIDTH-1:0]             s_data_wr,
    output logic [DATA_WIDTH/8-1:0]           s_mask,
    input  logic                              s_stall,
    input  logic [DATA_WIDTH-1:0]             s_data_rd,
    input  logic [DATA_WIDTH-1:0]             s_data_rd_2,
    output logic [N_MASTERS-1:0]              grant
);

    // state  | meaning
    // IDLE   | no owner; arbitrate among requesters starting at rr
    // BUSY   | owner registered, slave stalling its transaction
    // LOCKED | owner keeps the bus between transactions while m_lock is high

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr;

    logic [N_MASTERS-1:0] req;
    logic                 any_req;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     cur_owner;
    logic                 granted;
    logic                 active;
    int                   scan_idx;
    int                   owner_i;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(N_MASTERS - 1))
            return '0;
        return i + 1'b1;
    endfunction

    assign req     = m_read | m_write;
    assign any_req = |req;

    // Scan downward so the last hit is the first requester at or after rr.
    always_comb begin
        winner   = rr;
        scan_idx = 0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= N_MASTERS)
                scan_idx = scan_idx - N_MASTERS;
            if (req[scan_idx])
                winner = IDX_W'(scan_idx);
        end
    end

    always_comb begin
        granted   = 1'b0;
        cur_owner = owner;
        if (!rst) begin
            if (state == IDLE) begin
                granted   = any_req;
                cur_owner = winner;
            end else begin
                granted = 1'b1;
            end
        end
    end

    assign owner_i = int'(cur_owner);
    assign active  = granted & req[cur_owner];

    // A locked owner that is idle keeps the grant but puts nothing on the slave port.
    always_comb begin
        grant       = '0;
        m_stall     = req;
        m_data_rd   = '0;
        m_data_rd_2 = '0;
        s_address   = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_data_wr   = '0;
        s_mask      = '0;
        if (granted) begin
            grant[cur_owner]                            = 1'b1;
            m_stall[cur_owner]                          = active & s_stall;
            m_data_rd[owner_i*DATA_WIDTH +: DATA_WIDTH]   = s_data_rd;
            m_data_rd_2[owner_i*DATA_WIDTH +: DATA_WIDTH] = s_data_rd_2;
        end
        if (active) begin
            s_address = m_address[owner_i*ADDR_WIDTH +: ADDR_WIDTH];
            s_read    = m_read[cur_owner];
            s_write   = m_write[cur_owner];
            s_data_wr = m_data_wr[owner_i*DATA_WIDTH +: DATA_WIDTH];
            s_mask    = m_mask[owner_i*MASK_WIDTH +: MASK_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            rr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        if (s_stall) begin
                            state <= BUSY;
                            owner <= winner;
                        end else if (m_lock[winner]) begin
                            state <= LOCKED;
                            owner <= winner;
                        end else begin
                            rr <= next_idx(winner);
                        end
                    end
                end
                BUSY: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                        rr    <= next_idx(owner);
                    end else if (!s_stall) begin
                        if (m_lock[owner]) begin
                            state <= LOCKED;
                        end else begin
                            state <= IDLE;
                            rr    <= next_idx(owner);
                        end
                    end
                end
                LOCKED: begin
                    if (req[owner]) begin
                        if (s_stall) begin
                            state <= BUSY;
                        end else if (!m_lock[owner]) begin
                            state <= IDLE;
                            rr    <= next_idx(owner);
                        end
                    end else if (!m_lock[owner]) begin
                        state <= IDLE;
                        rr    <= next_idx(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a 2-master and a 4-master instance share one stimulus,
// both checked every cycle against an ownership model plus directed literal checks.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a [4];
    logic [31:0] wd [4];
    logic [3:0]  mk [4];
    logic [3:0]  rd, wr, lk;
    logic        ss;
    logic [31:0] sd, sd2;

    logic [63:0]  m_address2, m_data_wr2, m_data_rd2, m_data_rd_22;
    logic [7:0]   m_mask2;
    logic [1:0]   m_stall2, grant2;
    logic [31:0]  s_address2, s_data_wr2;
    logic         s_read2, s_write2;
    logic [3:0]   s_mask2;

    logic [127:0] m_address4, m_data_wr4, m_data_rd4, m_data_rd_24;
    logic [15:0]  m_mask4;
    logic [3:0]   m_stall4, grant4;
    logic [31:0]  s_address4, s_data_wr4;
    logic         s_read4, s_write4;
    logic [3:0]   s_mask4;

    assign m_address2 = {a[1], a[0]};
    assign m_data_wr2 = {wd[1], wd[0]};
    assign m_mask2    = {mk[1], mk[0]};
    assign m_address4 = {a[3], a[2], a[1], a[0]};
    assign m_data_wr4 = {wd[3], wd[2], wd[1], wd[0]};
    assign m_mask4    = {mk[3], mk[2], mk[1], mk[0]};

    bus_arbiter #(.N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst),
        .m_address(m_address2), .m_read(rd[1:0]), .m_write(wr[1:0]),
        .m_data_wr(m_data_wr2), .m_mask(m_mask2), .m_lock(lk[1:0]),
        .m_stall(m_stall2), .m_data_rd(m_data_rd2), .m_data_rd_2(m_data_rd_22),
        .s_address(s_address2), .s_read(s_read2), .s_write(s_write2),
        .s_data_wr(s_data_wr2), .s_mask(s_mask2),
        .s_stall(ss), .s_data_rd(sd), .s_data_rd_2(sd2),
        .grant(grant2)
    );

    bus_arbiter #(.N_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst),
        .m_address(m_address4), .m_read(rd), .m_write(wr),
        .m_data_wr(m_data_wr4), .m_mask(m_mask4), .m_lock(lk),
        .m_stall(m_stall4), .m_data_rd(m_data_rd4), .m_data_rd_2(m_data_rd_24),
        .s_address(s_address4), .s_read(s_read4), .s_write(s_write4),
        .s_data_wr(s_data_wr4), .s_mask(s_mask4),
        .s_stall(ss), .s_data_rd(sd), .s_data_rd_2(sd2),
        .grant(grant4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Both instances viewed through 4-master-wide arrays.
    logic [3:0]  act_grant [2];
    logic [3:0]  act_stall [2];
    logic [3:0]  act_smask [2];
    logic [31:0] act_saddr [2];
    logic [31:0] act_swd   [2];
    logic        act_sr    [2];
    logic        act_sw    [2];
    logic [31:0] act_rd    [2][4];
    logic [31:0] act_rd2   [2][4];

    always_comb begin
        act_grant[0] = {2'b00, grant2};
        act_grant[1] = grant4;
        act_stall[0] = {2'b00, m_stall2};
        act_stall[1] = m_stall4;
        act_smask[0] = s_mask2;
        act_smask[1] = s_mask4;
        act_saddr[0] = s_address2;
        act_saddr[1] = s_address4;
        act_swd[0]   = s_data_wr2;
        act_swd[1]   = s_data_wr4;
        act_sr[0]    = s_read2;
        act_sr[1]    = s_read4;
        act_sw[0]    = s_write2;
        act_sw[1]    = s_write4;
        act_rd[0][0]  = m_data_rd2[31:0];
        act_rd[0][1]  = m_data_rd2[63:32];
        act_rd[0][2]  = 32'h0;
        act_rd[0][3]  = 32'h0;
        act_rd2[0][0] = m_data_rd_22[31:0];
        act_rd2[0][1] = m_data_rd_22[63:32];
        act_rd2[0][2] = 32'h0;
        act_rd2[0][3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            act_rd[1][i]  = m_data_rd4[i*32 +: 32];
            act_rd2[1][i] = m_data_rd_24[i*32 +: 32];
        end
    end

    // Model: who holds the bus (-1 = nobody), whether the hold is a lock, and the next-turn pointer.
    int hold_m   [2] = '{-1, -1};
    bit bylock_m [2] = '{1'b0, 1'b0};
    int rr_m     [2] = '{0, 0};

    always @(negedge clk) begin : model_cmp
        int n, cur, j;
        logic [3:0]  rq, e_grant, e_stall, e_smask;
        logic [31:0] e_saddr, e_swd;
        logic        e_sr, e_sw;
        logic [31:0] e_rd [4];
        logic [31:0] e_rd2 [4];
        for (int d = 0; d < 2; d++) begin
            n  = (d == 0) ? 2 : 4;
            rq = '0;
            for (int i = 0; i < n; i++) rq[i] = rd[i] | wr[i];
            cur = -1;
            if (!rst) begin
                if (hold_m[d] >= 0) begin
                    cur = hold_m[d];
                end else begin
                    for (int k = 0; k < n; k++) begin
                        j = (rr_m[d] + k) % n;
                        if (cur < 0 && rq[j]) cur = j;
                    end
                end
            end
            e_grant = '0; e_stall = rq; e_smask = '0; e_saddr = '0; e_swd = '0;
            e_sr = 1'b0; e_sw = 1'b0;
            for (int i = 0; i < 4; i++) begin e_rd[i] = '0; e_rd2[i] = '0; end
            if (cur >= 0) begin
                e_grant[cur] = 1'b1;
                e_stall[cur] = rq[cur] & ss;
                e_rd[cur]    = sd;
                e_rd2[cur]   = sd2;
                if (rq[cur]) begin
                    e_saddr = a[cur]; e_swd = wd[cur]; e_smask = mk[cur];
                    e_sr = rd[cur]; e_sw = wr[cur];
                end
            end
            chk($sformatf("n%0d_grant", n),     64'(act_grant[d]), 64'(e_grant));
            chk($sformatf("n%0d_m_stall", n),   64'(act_stall[d]), 64'(e_stall));
            chk($sformatf("n%0d_s_address", n), 64'(act_saddr[d]), 64'(e_saddr));
            chk($sformatf("n%0d_s_read", n),    64'(act_sr[d]),    64'(e_sr));
            chk($sformatf("n%0d_s_write", n),   64'(act_sw[d]),    64'(e_sw));
            chk($sformatf("n%0d_s_data_wr", n), 64'(act_swd[d]),   64'(e_swd));
            chk($sformatf("n%0d_s_mask", n),    64'(act_smask[d]), 64'(e_smask));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("n%0d_m%0d_data_rd", n, i),   64'(act_rd[d][i]),  64'(e_rd[i]));
                chk($sformatf("n%0d_m%0d_data_rd_2", n, i), 64'(act_rd2[d][i]), 64'(e_rd2[i]));
            end
            if (rst) begin
                hold_m[d] = -1; bylock_m[d] = 1'b0; rr_m[d] = 0;
            end else if (cur >= 0) begin
                if (rq[cur] && ss) begin
                    hold_m[d] = cur; bylock_m[d] = 1'b0;
                end else if (rq[cur] && lk[cur]) begin
                    hold_m[d] = cur; bylock_m[d] = 1'b1;
                end else if (!rq[cur] && bylock_m[d] && lk[cur]) begin
                    hold_m[d] = cur;
                end else begin
                    hold_m[d] = -1; bylock_m[d] = 1'b0; rr_m[d] = (cur + 1) % n;
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ss = 1'b0; sd = '0; sd2 = '0;
        rd = '0; wr = '0; lk = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h100 * (i + 1); wd[i] = 32'hA000_0000 + i; mk[i] = 4'h3;
        end
        rd = 4'b0001;
        @(negedge clk);
        chk("rst_grant", 64'(grant2), 64'h0);
        chk("rst_m_stall", 64'(m_stall2), 64'h1);
        chk("rst_s_read", 64'(s_read2), 64'h0);
        adv(); adv();
        rst = 1'b0; rd = '0;

        // Two simultaneous readers alternate.
        rd = 4'b0011;
        @(negedge clk); chk("alt_grant0", 64'(grant2), 64'h1); chk("alt_stall0", 64'(m_stall2), 64'h2); adv();
        @(negedge clk); chk("alt_grant1", 64'(grant2), 64'h2); chk("alt_stall1", 64'(m_stall2), 64'h1); adv();
        @(negedge clk); chk("alt_grant2", 64'(grant2), 64'h1); adv();
        rd = '0; @(negedge clk); adv();

        // m1 write stalled 3 cycles while m0 waits.
        wr = 4'b0010; rd = 4'b0001; a[1] = 32'h0000_1000; wd[1] = 32'hDEAD_BEEF; mk[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            ss = (c < 3);
            @(negedge clk);
            chk($sformatf("wr_addr_c%0d", c), 64'(s_address2), 64'h1000);
            chk($sformatf("wr_data_c%0d", c), 64'(s_data_wr2), 64'hDEAD_BEEF);
            chk($sformatf("wr_mask_c%0d", c), 64'(s_mask2), 64'hF);
            chk($sformatf("wr_strobe_c%0d", c), 64'(s_write2), 64'h1);
            chk($sformatf("wr_grant_c%0d", c), 64'(grant2), 64'h2);
            adv();
        end
        wr = '0; ss = 1'b0;
        @(negedge clk); chk("wr_m0_cycle5", 64'(grant2), 64'h1); adv();
        rd = '0; @(negedge clk); adv();

        // Line rr up for m0, then a locked pair of reads with a gap.
        rd = 4'b0010; @(negedge clk); adv();
        rd = 4'b0011; lk = 4'b0001;
        @(negedge clk); chk("lock_grant0", 64'(grant2), 64'h1); adv();
        rd = 4'b0010;
        @(negedge clk); chk("lock_gap_grant", 64'(grant2), 64'h1);
        chk("lock_gap_sread", 64'(s_read2), 64'h0); chk("lock_gap_stall", 64'(m_stall2), 64'h2); adv();
        rd = 4'b0011;
        @(negedge clk); chk("lock_grant2", 64'(grant2), 64'h1); adv();
        rd = 4'b0010; lk = '0;
        @(negedge clk); chk("unlock_grant", 64'(grant2), 64'h1); adv();
        @(negedge clk); chk("after_unlock_m1", 64'(grant2), 64'h2); adv();
        rd = '0; @(negedge clk); adv();

        // Read data routed to the owner only.
        sd = 32'h1234_5678; sd2 = 32'hCAFE_F00D; rd = 4'b0010;
        @(negedge clk);
        chk("rdata_route", m_data_rd2, 64'h1234_5678_0000_0000);
        chk("rdata2_route", m_data_rd_22, 64'hCAFE_F00D_0000_0000);
        adv();
        rd = '0;

        // Reset while BUSY on m1.
        rd = 4'b0010; ss = 1'b1;
        @(negedge clk); chk("busy_m1_grant", 64'(grant2), 64'h2); adv();
        rst = 1'b1;
        @(negedge clk); chk("rst_busy_grant", 64'(grant2), 64'h0); chk("rst_busy_sread", 64'(s_read2), 64'h0); adv();
        rst = 1'b0; rd = 4'b0011; ss = 1'b0;
        @(negedge clk); chk("post_rst_m0", 64'(grant2), 64'h1); adv();
        rd = '0; @(negedge clk); adv();

        // N=4: sole requester m3 from rr=0, pointer wraps.
        rst = 1'b1; @(negedge clk); adv(); rst = 1'b0;
        rd = 4'b1000;
        @(negedge clk); chk("n4_m3_grant", 64'(grant4), 64'h8); chk("n4_m3_sread", 64'(s_read4), 64'h1); adv();
        rd = 4'b1001;
        @(negedge clk); chk("n4_wrap_m0", 64'(grant4), 64'h1); adv();

        // Sole requester is re-granted immediately.
        rd = 4'b0001;
        @(negedge clk); chk("sole_g0", 64'(grant2), 64'h1); adv();
        @(negedge clk); chk("sole_g1", 64'(grant2), 64'h1); adv();

        // Owner drops its request while BUSY.
        ss = 1'b1;
        @(negedge clk); adv();
        rd = '0;
        @(negedge clk); chk("drop_busy_grant", 64'(grant2), 64'h1); chk("drop_busy_sread", 64'(s_read2), 64'h0); adv();
        rd = 4'b0011; ss = 1'b0;
        @(negedge clk); chk("drop_rr_advanced", 64'(grant2), 64'h2); adv();
        rd = '0; @(negedge clk); adv();

        for (int c = 0; c < 400; c++) begin
            rd  = 4'($urandom) & 4'($urandom);
            wr  = 4'($urandom) & 4'($urandom) & ~rd;
            lk  = 4'($urandom) & 4'($urandom);
            ss  = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 49) == 0);
            sd  = $urandom; sd2 = $urandom;
            for (int i = 0; i < 4; i++) begin
                a[i] = $urandom; wd[i] = $urandom; mk[i] = 4'($urandom);
            end
            @(negedge clk); adv();
        end
        rst = 1'b0; rd = '0; wr = '0; lk = '0;
        @(negedge clk); adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
